hilo_mdu_ctrl: RTL and testbench
================================

HILO_MDU_CTRL -- requirements
Module: hilo_mdu_ctrl

Interface
REQ-001 SHALL have parameter MUL_LATENCY, default 3, meaning multiply wait cycles before commit.
REQ-002 SHALL have parameter DIV_CYCLES, default 32, meaning iterative divide steps.
REQ-003 SHALL have port clk  in  1  single system clock; all state changes on rising edge.
REQ-004 SHALL have port resetn  in  1  reset, synchronous, active-low.
REQ-005 SHALL have port req_valid  in  1  decoded MDU request present.
REQ-006 SHALL have port req_ready  out  1  controller can accept; high only in IDLE.
REQ-007 SHALL have port req_op  in  op_t  decoded op; MULT, MULTU, MUL, MADD, MADDU, MSUB, MSUBU, DIV, DIVU, MTHI and MTLO are serviced; all others are ignored.
REQ-008 SHALL have port req_a  in  32  rs operand.
REQ-009 SHALL have port req_b  in  32  rt operand.
REQ-010 SHALL have port flush  in  1  pipeline flush; abort in-flight op.
REQ-011 SHALL have port done  out  1  one-cycle pulse; op complete.
REQ-012 SHALL have port res  out  32  MUL GPR result, valid while done is high.
REQ-013 SHALL have port hi  out  32  architectural HI register.
REQ-014 SHALL have port lo  out  32  architectural LO register.

Function
REQ-015 SHALL accept a request on an edge where req_valid, req_ready and a serviced op are all high, and flush is low; operands and op are latched on that edge.
REQ-016 SHALL implement states IDLE, MUL_WAIT, DIV_RUN and DONE.
REQ-017 SHALL handle MTHI/MTLO by writing hi/lo with req_a on the accept edge, remaining in IDLE, with no done pulse.
REQ-018 SHALL handle multiply-class ops: IDLE -> MUL_WAIT for MUL_LATENCY cycles -> DONE; hi/lo commit on the edge entering DONE, so done is high in the 4th cycle after accept.
REQ-019 SHALL compute MULT/MADD/MSUB as signed 32x32->64 and MULTU/MADDU/MSUBU as unsigned.
REQ-020 SHALL write {hi,lo} = {hi,lo} +/- product for MADD*/MSUB* using 64-bit modulo arithmetic with the hi/lo values current at commit.
REQ-021 SHALL, for MUL, drive res = low 32 bits of the signed product and leave hi/lo unchanged.
REQ-022 SHALL handle DIV/DIVU: IDLE -> DIV_RUN for DIV_CYCLES cycles -> DONE, with lo = quotient and hi = remainder committed on entry to DONE.
REQ-023 SHALL, for DIV, take the quotient sign from a^b and the remainder sign from a, truncating toward zero; 0x80000000 / -1 gives lo=0x80000000, hi=0.
REQ-024 SHALL, on divide by zero (DIV or DIVU), give lo=0xFFFFFFFF and hi=req_a with no sign fix-up.
REQ-025 SHALL leave DONE for IDLE unconditionally after one cycle, with req_ready low in DONE.
REQ-026 SHALL, when flush is high in any state, go to IDLE next edge, suppress commit and done, and keep hi/lo unchanged; flush has priority over acceptance and over a commit falling on the same edge.
REQ-027 SHALL ignore req_valid while not in IDLE, with no queueing.
REQ-028 SHALL hold res at 0 except in DONE after MUL.

Reset
REQ-029 SHALL, with resetn low at an edge: state=IDLE, hi=0, lo=0, done=0, res=0, counters=0; req_ready is high the cycle after release.
REQ-030 SHALL abort any in-flight operation with reset and not commit it; reset has priority over flush and acceptance.

Structure
REQ-031 SHALL place the mdu state enum, MUL_LATENCY and DIV_CYCLES defaults in the shared mycpu package alongside op_t.
REQ-032 SHALL implement the iterative divider as sub-module mdu_divider (start, a, b, signed flag -> q, r, done), one quotient bit per cycle, restartable and abortable.

Verification
REQ-033 SHALL cover MULT a=0xFFFFFFFF, b=2 -> done in cycle 4 after accept, hi=0xFFFFFFFF, lo=0xFFFFFFFE; MULTU with the same operands -> hi=1, lo=0xFFFFFFFE.
REQ-034 SHALL cover DIV a=-7, b=2 -> done 33 cycles after accept, lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU a=7, b=0 -> lo=0xFFFFFFFF, hi=7.
REQ-035 SHALL cover MTHI 5 then MADD a=2, b=3 with lo=0 -> hi=5, lo=6; then MSUB a=1, b=7 -> hi=4, lo=0xFFFFFFFF.
REQ-036 SHALL cover flush asserted in DIV_RUN cycle 10 -> IDLE next cycle, no done, hi/lo unchanged, new MULT accepted immediately.
REQ-037 SHALL cover MUL a=-3, b=4 -> res=0xFFFFFFF4 with done, hi/lo unchanged; req_valid during busy is ignored.
REQ-038 SHALL cover resetn low during MUL_WAIT -> hi=lo=0, req_ready high after release.

Source files
------------

// File: rtl/mycpu_pkg.sv
// Shared CPU definitions: decoded op codes, MDU controller states and
// MDU timing defaults, plus small op-classification helpers.
package mycpu_pkg;

   typedef enum logic [4:0] {
      OP_NOP,
      OP_ALU,
      OP_MFHI,
      OP_MFLO,
      OP_MULT,
      OP_MULTU,
      OP_MUL,
      OP_MADD,
      OP_MADDU,
      OP_MSUB,
      OP_MSUBU,
      OP_DIV,
      OP_DIVU,
      OP_MTHI,
      OP_MTLO
   } op_t;

   typedef enum logic [1:0] {
      MDU_IDLE,
      MDU_MUL_WAIT,
      MDU_DIV_RUN,
      MDU_DONE
   } mdu_state_t;

   localparam int MDU_MUL_LATENCY = 3;
   localparam int MDU_DIV_CYCLES  = 32;

   function automatic logic op_is_mul(input op_t op);
      return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_MUL) ||
             (op == OP_MADD) || (op == OP_MADDU) ||
             (op == OP_MSUB) || (op == OP_MSUBU);
   endfunction

   function automatic logic op_mul_signed(input op_t op);
      return (op == OP_MULT) || (op == OP_MUL) || (op == OP_MADD) || (op == OP_MSUB);
   endfunction

   function automatic logic op_is_div(input op_t op);
      return (op == OP_DIV) || (op == OP_DIVU);
   endfunction

   function automatic logic op_is_mt(input op_t op);
      return (op == OP_MTHI) || (op == OP_MTLO);
   endfunction

   function automatic logic op_serviced(input op_t op);
      return op_is_mul(op) || op_is_div(op) || op_is_mt(op);
   endfunction

endpackage

// File: rtl/mdu_divider.sv
// Iterative restoring divider: one quotient bit per cycle on magnitudes,
// sign fix-up and divide-by-zero handling on the outputs. q/r/done reflect
// the step being taken this cycle, so the owner can commit on that edge.
// Each step consumes one dividend bit, so STEPS is expected to be 32.
module mdu_divider
   import mycpu_pkg::*;
#(
   parameter int STEPS = MDU_DIV_CYCLES
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        start,
   input  logic        abort,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        sgn,
   output logic [31:0] q,
   output logic [31:0] r,
   output logic        done
);

   localparam int CNT_W = $clog2(STEPS + 1);

   logic [31:0]      rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d, a_q, a_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             busy_q, busy_d, negq_q, negq_d, negr_q, negr_d, bzero_q, bzero_d;

   logic        a_neg, b_neg, last;
   logic [31:0] a_mag, b_mag, rem_n, quo_n;
   logic [32:0] rem_sh, diff;

   // Operand conditioning, one restoring step, and next-state selection
   always_comb begin
      a_neg  = sgn && a[31];
      b_neg  = sgn && b[31];
      a_mag  = a_neg ? -a : a;
      b_mag  = b_neg ? -b : b;
      rem_sh = {rem_q, quo_q[31]};
      diff   = rem_sh - {1'b0, dvs_q};
      rem_n  = diff[32] ? rem_sh[31:0] : diff[31:0];
      quo_n  = {quo_q[30:0], ~diff[32]};
      last   = busy_q && (cnt_q == CNT_W'(STEPS - 1));

      rem_d   = rem_q;
      quo_d   = quo_q;
      dvs_d   = dvs_q;
      a_d     = a_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      negq_d  = negq_q;
      negr_d  = negr_q;
      bzero_d = bzero_q;

      if (abort) begin
         busy_d = 1'b0;
      end else if (start) begin
         rem_d   = '0;
         quo_d   = a_mag;
         dvs_d   = b_mag;
         a_d     = a;
         cnt_d   = '0;
         busy_d  = 1'b1;
         negq_d  = a_neg ^ b_neg;
         negr_d  = a_neg;
         bzero_d = (b == 32'd0);
      end else if (busy_q) begin
         rem_d = rem_n;
         quo_d = quo_n;
         cnt_d = cnt_q + CNT_W'(1);
         if (last) begin
            busy_d = 1'b0;
         end
      end
   end

   // Result formatting: divide-by-zero bypasses the sign fix-up
   always_comb begin
      q    = bzero_q ? 32'hFFFF_FFFF : (negq_q ? -quo_n : quo_n);
      r    = bzero_q ? a_q : (negr_q ? -rem_n : rem_n);
      done = last;
   end

   // Divider state registers
   always_ff @(posedge clk) begin
      if (!resetn) begin
         rem_q   <= '0;
         quo_q   <= '0;
         dvs_q   <= '0;
         a_q     <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         negq_q  <= 1'b0;
         negr_q  <= 1'b0;
         bzero_q <= 1'b0;
      end else begin
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         dvs_q   <= dvs_d;
         a_q     <= a_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         negq_q  <= negq_d;
         negr_q  <= negr_d;
         bzero_q <= bzero_d;
      end
   end

endmodule

// File: rtl/hilo_mdu_ctrl.sv
// HI/LO multiply-divide controller: accepts one MDU op at a time, waits a
// fixed multiply latency or runs the iterative divider, then commits HI/LO
// (or the MUL GPR result) on entry to DONE. Flush aborts without commit.
module hilo_mdu_ctrl
   import mycpu_pkg::*;
#(
   parameter int MUL_LATENCY = MDU_MUL_LATENCY,
   parameter int DIV_CYCLES  = MDU_DIV_CYCLES
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        req_valid,
   output logic        req_ready,
   input  op_t         req_op,
   input  logic [31:0] req_a,
   input  logic [31:0] req_b,
   input  logic        flush,
   output logic        done,
   output logic [31:0] res,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   mdu_state_t  state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   op_t         op_q, op_d;
   logic [31:0] a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d, res_q, res_d;
   logic        done_q, done_d;

   logic        accept, div_start, div_done;
   logic [31:0] div_q, div_r;
   logic [63:0] ext_a, ext_b, prod, acc;

   mdu_divider #(
      .STEPS (DIV_CYCLES)
   ) u_div (
      .clk    (clk),
      .resetn (resetn),
      .start  (div_start),
      .abort  (flush),
      .a      (req_a),
      .b      (req_b),
      .sgn    (req_op == OP_DIV),
      .q      (div_q),
      .r      (div_r),
      .done   (div_done)
   );

   assign req_ready = (state_q == MDU_IDLE);
   assign done      = done_q;
   assign res       = res_q;
   assign hi        = hi_q;
   assign lo        = lo_q;

   // 64-bit product of the latched operands; extension picks signedness
   always_comb begin
      ext_a = op_mul_signed(op_q) ? {{32{a_q[31]}}, a_q} : {32'd0, a_q};
      ext_b = op_mul_signed(op_q) ? {{32{b_q[31]}}, b_q} : {32'd0, b_q};
      prod  = ext_a * ext_b;
      acc   = {hi_q, lo_q};
   end

   // Next-state, commit and done/res generation; flush overrides everything
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      op_d      = op_q;
      a_d       = a_q;
      b_d       = b_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      res_d     = 32'd0;
      done_d    = 1'b0;
      div_start = 1'b0;
      accept    = req_valid && (state_q == MDU_IDLE) && op_serviced(req_op) && !flush;

      case (state_q)
         MDU_IDLE: begin
            if (accept) begin
               if (req_op == OP_MTHI) begin
                  hi_d = req_a;
               end else if (req_op == OP_MTLO) begin
                  lo_d = req_a;
               end else if (op_is_mul(req_op)) begin
                  op_d    = req_op;
                  a_d     = req_a;
                  b_d     = req_b;
                  cnt_d   = 8'd0;
                  state_d = MDU_MUL_WAIT;
               end else begin
                  op_d      = req_op;
                  div_start = 1'b1;
                  state_d   = MDU_DIV_RUN;
               end
            end
         end
         MDU_MUL_WAIT: begin
            if (cnt_q == 8'(MUL_LATENCY - 1)) begin
               state_d = MDU_DONE;
               done_d  = 1'b1;
               case (op_q)
                  OP_MUL:              res_d = prod[31:0];
                  OP_MADD, OP_MADDU:   {hi_d, lo_d} = acc + prod;
                  OP_MSUB, OP_MSUBU:   {hi_d, lo_d} = acc - prod;
                  default:             {hi_d, lo_d} = prod;
               endcase
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         MDU_DIV_RUN: begin
            if (div_done) begin
               state_d = MDU_DONE;
               done_d  = 1'b1;
               hi_d    = div_r;
               lo_d    = div_q;
            end
         end
         MDU_DONE: begin
            state_d = MDU_IDLE;
         end
         default: begin
            state_d = MDU_IDLE;
         end
      endcase

      if (flush) begin
         state_d = MDU_IDLE;
         hi_d    = hi_q;
         lo_d    = lo_q;
         res_d   = 32'd0;
         done_d  = 1'b0;
      end
   end

   // Controller registers
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q <= MDU_IDLE;
         cnt_q   <= 8'd0;
         op_q    <= OP_NOP;
         a_q     <= 32'd0;
         b_q     <= 32'd0;
         hi_q    <= 32'd0;
         lo_q    <= 32'd0;
         res_q   <= 32'd0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         res_q   <= res_d;
         done_q  <= done_d;
      end
   end

endmodule

// File: tb/tb_hilo_mdu_ctrl.sv
// Bench for hilo_mdu_ctrl: fixed vector table, hand-written flush/reset/busy
// sequences, and randomized ops against an arithmetic reference model.
module tb_hilo_mdu_ctrl;
   import mycpu_pkg::*;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        req_valid = 1'b0;
   logic        flush = 1'b0;
   op_t         req_op = OP_NOP;
   logic [31:0] req_a = 32'd0;
   logic [31:0] req_b = 32'd0;
   logic        req_ready, done;
   logic [31:0] res, hi, lo;

   int tests = 0;
   int fails = 0;

   logic [31:0] m_hi, m_lo, m_res;
   int          m_lat;

   typedef struct {
      op_t         op;
      logic [31:0] a, b, hi, lo, res;
      int          lat;
   } vec_t;

   vec_t tbl[13];
   op_t  ops[11];

   hilo_mdu_ctrl dut (
      .clk       (clk),
      .resetn    (resetn),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_op    (req_op),
      .req_a     (req_a),
      .req_b     (req_b),
      .flush     (flush),
      .done      (done),
      .res       (res),
      .hi        (hi),
      .lo        (lo)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model: architectural effect of one op on HI/LO/res plus latency
   task automatic model(input op_t op, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] p, acc;
      longint      sa, sb, q, r;
      sa    = longint'($signed(a));
      sb    = longint'($signed(b));
      acc   = {m_hi, m_lo};
      m_res = 32'd0;
      m_lat = MDU_MUL_LATENCY + 1;
      if (op == OP_MULT || op == OP_MADD || op == OP_MSUB || op == OP_MUL)
         p = 64'(sa * sb);
      else
         p = {32'd0, a} * {32'd0, b};
      case (op)
         OP_MULT, OP_MULTU: acc = p;
         OP_MADD, OP_MADDU: acc = acc + p;
         OP_MSUB, OP_MSUBU: acc = acc - p;
         OP_MUL:            m_res = p[31:0];
         OP_DIV, OP_DIVU: begin
            m_lat = MDU_DIV_CYCLES + 1;
            if (b == 32'd0) begin
               acc = {a, 32'hFFFF_FFFF};
            end else begin
               if (op == OP_DIV) begin
                  q = sa / sb;
                  r = sa % sb;
               end else begin
                  q = longint'({32'd0, a}) / longint'({32'd0, b});
                  r = longint'({32'd0, a}) % longint'({32'd0, b});
               end
               acc = {r[31:0], q[31:0]};
            end
         end
         OP_MTHI: begin acc[63:32] = a; m_lat = 0; end
         OP_MTLO: begin acc[31:0]  = a; m_lat = 0; end
         default: m_lat = 0;
      endcase
      {m_hi, m_lo} = acc;
   endtask

   // Issue one request at a negedge; report cycles from accept to done (0 = none)
   task automatic run_op(input op_t op, input logic [31:0] a, input logic [31:0] b,
                         input bit noise, output int lat, output logic [31:0] rs);
      int guard;
      int lim;
      guard = 0;
      lat   = 0;
      rs    = 32'd0;
      while (!req_ready && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      if (!req_ready) chk("ready_wait", 64'(req_ready), 64'd1);
      req_valid = 1'b1;
      req_op    = op;
      req_a     = a;
      req_b     = b;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_op    = OP_NOP;
      lim = (op == OP_MTHI || op == OP_MTLO) ? 3 : 60;
      for (int k = 1; k <= lim; k++) begin
         @(negedge clk);
         if (noise && k == 1) begin
            req_valid = 1'b1;
            req_op    = OP_MTHI;
            req_a     = 32'hDEAD_BEEF;
         end
         if (noise && k == 3) begin
            req_valid = 1'b0;
            req_op    = OP_NOP;
         end
         if (done) begin
            lat = k;
            rs  = res;
            break;
         end
      end
      if (lat > 0) begin
         @(negedge clk);
         chk("done_pulse", 64'(done), 64'd0);
         chk("idle_ready", 64'(req_ready), 64'd1);
      end
   endtask

   task automatic check_op(input string tag, input op_t op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] ehi, input logic [31:0] elo, input logic [31:0] eres,
                           input int elat, input bit noise);
      int          lat;
      logic [31:0] rs;
      run_op(op, a, b, noise, lat, rs);
      chk($sformatf("%s_lat", tag), 64'(lat), 64'(elat));
      chk($sformatf("%s_hi", tag), 64'(hi), 64'(ehi));
      chk($sformatf("%s_lo", tag), 64'(lo), 64'(elo));
      chk($sformatf("%s_res", tag), 64'(rs), 64'(eres));
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 6))
         0:       return 32'd0;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'h7FFF_FFFF;
         4:       return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      int seen;
      tbl[0]  = '{OP_MULT,  32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd0,         4};
      tbl[1]  = '{OP_MULTU, 32'hFFFF_FFFF, 32'd2,         32'd1,         32'hFFFF_FFFE, 32'd0,         4};
      tbl[2]  = '{OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'd0,         33};
      tbl[3]  = '{OP_DIVU,  32'd7,         32'd0,         32'd7,         32'hFFFF_FFFF, 32'd0,         33};
      tbl[4]  = '{OP_MTLO,  32'd0,         32'd0,         32'd7,         32'd0,         32'd0,         0};
      tbl[5]  = '{OP_MTHI,  32'd5,         32'd0,         32'd5,         32'd0,         32'd0,         0};
      tbl[6]  = '{OP_MADD,  32'd2,         32'd3,         32'd5,         32'd6,         32'd0,         4};
      tbl[7]  = '{OP_MSUB,  32'd1,         32'd7,         32'd4,         32'hFFFF_FFFF, 32'd0,         4};
      tbl[8]  = '{OP_MUL,   32'hFFFF_FFFD, 32'd4,         32'd4,         32'hFFFF_FFFF, 32'hFFFF_FFF4, 4};
      tbl[9]  = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 32'd0,         33};
      tbl[10] = '{OP_MADDU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h8000_0001, 32'd0,         4};
      tbl[11] = '{OP_MSUBU, 32'd1,         32'd1,         32'hFFFF_FFFE, 32'h8000_0000, 32'd0,         4};
      tbl[12] = '{OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 32'd0,         33};
      ops = '{OP_MULT, OP_MULTU, OP_MUL, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU,
              OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO};

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_hi", 64'(hi), 64'd0);
      chk("rst_lo", 64'(lo), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_res", 64'(res), 64'd0);
      resetn = 1'b1;
      @(negedge clk);
      chk("rst_ready", 64'(req_ready), 64'd1);

      // Table vectors
      for (int i = 0; i < 13; i++) begin
         check_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b,
                  tbl[i].hi, tbl[i].lo, tbl[i].res, tbl[i].lat, 1'b0);
      end
      m_hi = tbl[12].hi;
      m_lo = tbl[12].lo;

      // Unserviced op is ignored
      req_valid = 1'b1; req_op = OP_MFHI; req_a = 32'h123;
      @(posedge clk); #1; req_valid = 1'b0; req_op = OP_NOP;
      seen = 0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         if (done || !req_ready) seen++;
      end
      chk("unsvc_idle", 64'(seen), 64'd0);
      chk("unsvc_hi", 64'(hi), 64'(m_hi));

      // Flush beats acceptance on the same edge
      @(negedge clk);
      flush = 1'b1; req_valid = 1'b1; req_op = OP_MTHI; req_a = 32'h1234;
      @(posedge clk); #1; flush = 1'b0; req_valid = 1'b0; req_op = OP_NOP;
      @(negedge clk);
      chk("flush_acc_hi", 64'(hi), 64'(m_hi));

      // MUL while req_valid is pulsed during busy
      model(OP_MUL, 32'hFFFF_FFFD, 32'd4);
      check_op("mul_busy", OP_MUL, 32'hFFFF_FFFD, 32'd4, m_hi, m_lo, m_res, m_lat, 1'b1);

      // Flush in DIV_RUN cycle 10
      req_valid = 1'b1; req_op = OP_DIV; req_a = 32'd100; req_b = 32'd7;
      @(posedge clk); #1; req_valid = 1'b0; req_op = OP_NOP;
      seen = 0;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (done) seen++;
      end
      flush = 1'b1;
      @(posedge clk); #1; flush = 1'b0;
      @(negedge clk);
      chk("flush_ready", 64'(req_ready), 64'd1);
      chk("flush_nodone", 64'(seen + int'(done)), 64'd0);
      chk("flush_hi", 64'(hi), 64'(m_hi));
      chk("flush_lo", 64'(lo), 64'(m_lo));
      model(OP_MULT, 32'd3, 32'd5);
      check_op("post_flush", OP_MULT, 32'd3, 32'd5, m_hi, m_lo, m_res, m_lat, 1'b0);

      // Randomized ops against the model
      for (int i = 0; i < 40; i++) begin
         op_t         op;
         logic [31:0] a, b;
         op = ops[$urandom_range(0, 10)];
         a  = pick();
         b  = pick();
         model(op, a, b);
         check_op($sformatf("rnd%0d_%s", i, op.name()), op, a, b, m_hi, m_lo, m_res, m_lat, 1'b0);
      end

      // Reset during MUL_WAIT
      @(negedge clk);
      req_valid = 1'b1; req_op = OP_MULT; req_a = 32'd6; req_b = 32'd7;
      @(posedge clk); #1; req_valid = 1'b0; req_op = OP_NOP;
      @(negedge clk);
      @(negedge clk);
      resetn = 1'b0;
      @(posedge clk); #1; resetn = 1'b1;
      @(negedge clk);
      chk("mrst_hi", 64'(hi), 64'd0);
      chk("mrst_lo", 64'(lo), 64'd0);
      chk("mrst_ready", 64'(req_ready), 64'd1);
      chk("mrst_res", 64'(res), 64'd0);
      seen = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (done) seen++;
      end
      chk("mrst_nodone", 64'(seen), 64'd0);
      chk("mrst_hi_after", 64'(hi), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
